cache_controller: RTL and testbench

- Sits between the MEM pipeline stage and the two-way data cache / external SRAM port.
- Translates pipeline byte addresses into the cache's 17-bit word address (tag 10, index 6, offset 1).
- Handles hits combinationally. Services read misses by fetching a 64-bit line from SRAM and filling the cache.
- Stores are write-through to SRAM; the matching cache line is invalidated.
- Deasserts ready to freeze the pipeline while SRAM traffic is outstanding.

---
 rtl/cache_pkg.sv | 18 +
 rtl/cache_addr_map.sv | 20 ++
 rtl/cache_controller.sv | 123 ++++++++++++
 tb/tb_cache_controller.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared constants and state encoding for the data-cache controller.
// The cache word address is laid out as tag 10 | index 6 | offset 1.
package cache_pkg;

  localparam int unsigned BASE_ADDR = 1024;
  localparam int unsigned TAG_W     = 10;
  localparam int unsigned INDEX_W   = 6;
  localparam int unsigned LINE_W    = 64;
  localparam int unsigned WORD_W    = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_MISS = 2'd1,
    FILL    = 2'd2,
    WR      = 2'd3
  } state_t;

endpackage

// File: rtl/cache_addr_map.sv
// Translates a pipeline byte address into the cache word address.
// Also produces the aligned two-word line address used for SRAM line reads.
module cache_addr_map #(
  parameter int unsigned BASE_ADDR = cache_pkg::BASE_ADDR,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned WADDR_W   = 17
) (
  input  logic [ADDR_W-1:0]  i_byteAddr,
  output logic [WADDR_W-1:0] o_wordAddr,
  output logic [WADDR_W-1:0] o_lineAddr
);

  logic [ADDR_W-1:0] w_offset;

  // Data memory starts at BASE_ADDR, so word 0 sits at that byte address.
  assign w_offset   = i_byteAddr - ADDR_W'(BASE_ADDR);
  assign o_wordAddr = w_offset[WADDR_W+1:2];
  assign o_lineAddr = {o_wordAddr[WADDR_W-1:1], 1'b0};

endmodule

// File: rtl/cache_controller.sv
// MEM-stage data-cache controller: combinational hits, line fill on read miss,
// write-through stores with invalidate-on-hit, and a ready signal that freezes the pipe.
module cache_controller
  import cache_pkg::*;
#(
  parameter int unsigned BASE_ADDR = cache_pkg::BASE_ADDR,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned WADDR_W   = 17
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_r_en,
  input  logic                mem_w_en,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [WORD_W-1:0]   mem_wdata,
  output logic [WORD_W-1:0]   mem_rdata,
  output logic                ready,
  output logic [WADDR_W-1:0]  cache_addr,
  output logic                cache_read_en,
  output logic                cache_write_en,
  output logic                cache_is_store,
  output logic [LINE_W-1:0]   cache_fill_data,
  input  logic [WORD_W-1:0]   cache_rdata,
  input  logic                cache_hit,
  output logic                sram_req,
  output logic                sram_we,
  output logic [WADDR_W-1:0]  sram_addr,
  output logic [WORD_W-1:0]   sram_wdata,
  input  logic [LINE_W-1:0]   sram_rdata,
  input  logic                sram_ready
);

  state_t              r_state;
  state_t              w_nextState;
  logic [LINE_W-1:0]   r_lineBuf;
  logic [WADDR_W-1:0]  w_wordAddr;
  logic [WADDR_W-1:0]  w_lineAddr;

  cache_addr_map #(
    .BASE_ADDR (BASE_ADDR),
    .ADDR_W    (ADDR_W),
    .WADDR_W   (WADDR_W)
  ) u_addrMap (
    .i_byteAddr (mem_addr),
    .o_wordAddr (w_wordAddr),
    .o_lineAddr (w_lineAddr)
  );

  assign cache_addr      = w_wordAddr;
  assign cache_fill_data = r_lineBuf;

  // The line buffer captures only the completing line read, so a reset mid-miss leaves it clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_lineBuf <= '0;
    end else begin
      r_state <= w_nextState;
      if (r_state == RD_MISS && sram_ready) begin
        r_lineBuf <= sram_rdata;
      end
    end
  end

  always_comb begin
    w_nextState    = r_state;
    ready          = 1'b0;
    mem_rdata      = '0;
    cache_read_en  = 1'b0;
    cache_write_en = 1'b0;
    cache_is_store = 1'b0;
    sram_req       = 1'b0;
    sram_we        = 1'b0;
    sram_addr      = '0;
    sram_wdata     = '0;
    if (!rst) begin
      unique case (r_state)
        IDLE: begin
          ready = 1'b1;
          // Stores win over loads when both are raised.
          if (mem_w_en) begin
            cache_is_store = 1'b1;
            ready          = 1'b0;
            w_nextState    = WR;
          end else if (mem_r_en) begin
            if (cache_hit) begin
              cache_read_en = 1'b1;
              mem_rdata     = cache_rdata;
            end else begin
              ready       = 1'b0;
              w_nextState = RD_MISS;
            end
          end
        end
        RD_MISS: begin
          sram_req  = 1'b1;
          sram_addr = w_lineAddr;
          if (sram_ready) begin
            w_nextState = FILL;
          end
        end
        FILL: begin
          cache_write_en = 1'b1;
          mem_rdata      = w_wordAddr[0] ? r_lineBuf[63:32] : r_lineBuf[31:0];
          ready          = 1'b1;
          w_nextState    = IDLE;
        end
        WR: begin
          sram_req   = 1'b1;
          sram_we    = 1'b1;
          sram_addr  = w_wordAddr;
          sram_wdata = mem_wdata;
          ready      = sram_ready;
          if (sram_ready) begin
            w_nextState = IDLE;
          end
        end
        default: w_nextState = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_controller.sv
// Directed self-checking bench for cache_controller: misses, hits, stores,
// load/store priority, reset during a miss, and idle behaviour.
module tb_cache_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_r_en;
  logic        mem_w_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        ready;
  logic [16:0] cache_addr;
  logic        cache_read_en;
  logic        cache_write_en;
  logic        cache_is_store;
  logic [63:0] cache_fill_data;
  logic [31:0] cache_rdata;
  logic        cache_hit;
  logic        sram_req;
  logic        sram_we;
  logic [16:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [63:0] sram_rdata;
  logic        sram_ready;

  int checkCount = 0;
  int failCount  = 0;

  cache_controller dut (
    .clk             (clk),
    .rst             (rst),
    .mem_r_en        (mem_r_en),
    .mem_w_en        (mem_w_en),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .ready           (ready),
    .cache_addr      (cache_addr),
    .cache_read_en   (cache_read_en),
    .cache_write_en  (cache_write_en),
    .cache_is_store  (cache_is_store),
    .cache_fill_data (cache_fill_data),
    .cache_rdata     (cache_rdata),
    .cache_hit       (cache_hit),
    .sram_req        (sram_req),
    .sram_we         (sram_we),
    .sram_addr       (sram_addr),
    .sram_wdata      (sram_wdata),
    .sram_rdata      (sram_rdata),
    .sram_ready      (sram_ready)
  );

  always #5 clk = ~clk;

  // Drive request inputs just after the falling edge; outputs settle well before the next rising edge.
  task automatic applyStimulus(input logic rEn, input logic wEn, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic hit, input logic [31:0] crdata,
                               input logic sReady, input logic [63:0] sRdata);
    @(negedge clk);
    mem_r_en    = rEn;
    mem_w_en    = wEn;
    mem_addr    = addr;
    mem_wdata   = wdata;
    cache_hit   = hit;
    cache_rdata = crdata;
    sram_ready  = sReady;
    sram_rdata  = sRdata;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    rst        = 1'b1;
    mem_r_en   = 1'b0;
    mem_w_en   = 1'b0;
    mem_addr   = 32'h400;
    mem_wdata  = '0;
    cache_rdata = '0;
    cache_hit  = 1'b0;
    sram_rdata = '0;
    sram_ready = 1'b0;
    repeat (2) @(posedge clk);

    // Reset forces the handshake and read data low even with a hitting load present.
    applyStimulus(1, 0, 32'h400, 0, 1, 32'hCAFE_F00D, 0, 0);
    checkOutput("rst_ready", ready, 0);
    checkOutput("rst_rdata", mem_rdata, 0);
    checkOutput("rst_strobes", {sram_req, cache_read_en, cache_write_en, cache_is_store}, 0);
    checkOutput("rst_fill", cache_fill_data, 0);
    @(negedge clk);
    rst = 1'b0;

    // Case 1: read miss at 0x400, line arrives on the third request cycle.
    applyStimulus(1, 0, 32'h400, 0, 0, 0, 0, 0);
    checkOutput("c1_miss_ready", ready, 0);
    checkOutput("c1_cache_addr", cache_addr, 17'h0);
    checkOutput("c1_idle_noreq", sram_req, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 32'h400, 0, 0, 0, (i == 2), 64'hBBBB_BBBB_AAAA_AAAA);
      checkOutput("c1_sram_req", {sram_req, sram_we}, 2'b10);
      checkOutput("c1_sram_addr", sram_addr, 17'h0);
      checkOutput("c1_wait_ready", ready, 0);
    end
    applyStimulus(1, 0, 32'h400, 0, 0, 0, 0, 0);
    checkOutput("c1_fill_we", cache_write_en, 1);
    checkOutput("c1_fill_data", cache_fill_data, 64'hBBBB_BBBB_AAAA_AAAA);
    checkOutput("c1_fill_rdata", mem_rdata, 32'hAAAA_AAAA);
    checkOutput("c1_fill_ready", ready, 1);
    checkOutput("c1_fill_rd_en", {cache_read_en, sram_req}, 0);

    // Case 2: hit at 0x404 completes in the same cycle.
    applyStimulus(1, 0, 32'h404, 0, 1, 32'hBBBB_BBBB, 0, 0);
    checkOutput("c2_ready", ready, 1);
    checkOutput("c2_rdata", mem_rdata, 32'hBBBB_BBBB);
    checkOutput("c2_rd_en", cache_read_en, 1);
    checkOutput("c2_addr", cache_addr, 17'h1);
    checkOutput("c2_noreq", sram_req, 0);
    @(posedge clk);
    #1;
    checkOutput("c2_stay_idle", {ready, sram_req}, 2'b10);

    // Case 3: write-through store at 0x408, SRAM completes on the second WR cycle.
    applyStimulus(0, 1, 32'h408, 32'h1234_5678, 0, 0, 0, 0);
    checkOutput("c3_is_store", cache_is_store, 1);
    checkOutput("c3_ready0", ready, 0);
    checkOutput("c3_idle_noreq", sram_req, 0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 1, 32'h408, 32'h1234_5678, 0, 0, (i == 1), 0);
      checkOutput("c3_store_pulse", cache_is_store, 0);
      checkOutput("c3_req_we", {sram_req, sram_we}, 2'b11);
      checkOutput("c3_sram_addr", sram_addr, 17'h2);
      checkOutput("c3_sram_wdata", sram_wdata, 32'h1234_5678);
      checkOutput("c3_ready", ready, (i == 1));
      checkOutput("c3_no_fill", cache_write_en, 0);
    end
    applyStimulus(0, 0, 32'h408, 0, 0, 0, 0, 0);
    checkOutput("c3_back_idle", {ready, sram_req}, 2'b10);

    // Case 4: simultaneous load and store take the store path.
    applyStimulus(1, 1, 32'h40C, 32'h5555_AAAA, 1, 32'h1111_1111, 0, 0);
    checkOutput("c4_is_store", cache_is_store, 1);
    checkOutput("c4_no_lookup", {cache_read_en, ready}, 0);
    applyStimulus(1, 1, 32'h40C, 32'h5555_AAAA, 1, 32'h1111_1111, 1, 0);
    checkOutput("c4_req_we", {sram_req, sram_we}, 2'b11);
    checkOutput("c4_sram_addr", sram_addr, 17'h3);
    checkOutput("c4_ready", ready, 1);

    // Odd word with high tag bits: line address clears bit 0, fill returns the upper half.
    applyStimulus(1, 0, 32'h0006_B334, 0, 0, 0, 0, 0);
    checkOutput("odd_cache_addr", cache_addr, 17'h1ABCD);
    applyStimulus(1, 0, 32'h0006_B334, 0, 0, 0, 1, 64'hDEAD_BEEF_0BAD_F00D);
    checkOutput("odd_line_addr", sram_addr, 17'h1ABCC);
    applyStimulus(1, 0, 32'h0006_B334, 0, 0, 0, 0, 0);
    checkOutput("odd_fill_rdata", mem_rdata, 32'hDEAD_BEEF);
    checkOutput("odd_fill_we", cache_write_en, 1);

    // Case 5: reset one cycle into a read miss abandons it without a fill.
    applyStimulus(1, 0, 32'h400, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 32'h400, 0, 0, 0, 0, 0);
    checkOutput("c5_in_miss", sram_req, 1);
    rst = 1'b1;
    #1;
    checkOutput("c5_rst_req", {sram_req, ready}, 0);
    applyStimulus(0, 0, 32'h400, 0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF);
    rst = 1'b0;
    #1;
    checkOutput("c5_idle_ready", ready, 1);
    checkOutput("c5_no_fill", {cache_write_en, sram_req}, 0);
    applyStimulus(0, 0, 32'h400, 0, 0, 0, 0, 0);
    checkOutput("c5_no_fill_after", cache_write_en, 0);
    checkOutput("c5_linebuf_clr", cache_fill_data, 0);

    // Case 6: idle with spurious sram_ready pulses.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 0, 32'h400, 0, 0, 0, i[0], 64'h1234);
      checkOutput("c6_ready", ready, 1);
      checkOutput("c6_strobes", {sram_req, cache_read_en, cache_write_en, cache_is_store}, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
